// File: rtl/io_fifo_port_pkg.sv
// Shared constants for the io_fifo_port responder: register offsets,
// CTRL/STATUS bit positions and the bus-side state encoding.
package io_fifo_port_pkg;

    // Register offsets within the 4-port window
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    // CTRL write bits
    localparam int CTRL_IO32_EN    = 0;
    localparam int CTRL_FLUSH      = 1;
    localparam int CTRL_CLR_STICKY = 2;

    // STATUS bit positions (pointers are 2-bit fields)
    localparam int STAT_RX_NONEMPTY = 0;
    localparam int STAT_TX_FULL     = 1;
    localparam int STAT_RX_UNF      = 2;
    localparam int STAT_TX_OVF      = 3;
    localparam int STAT_RD_PTR      = 4;
    localparam int STAT_WR_PTR      = 6;
    localparam int STAT_W           = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/io_fifo_port_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags and a
// synchronous flush. Push is ignored when full, pop ignored when empty.
module io_fifo_port_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_idx];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Index and occupancy tracking
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_idx <= wr_idx + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_idx <= rd_idx + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_fifo_port.sv
// Byte-serial CPU I/O bus responder bridging a DATA port to RX/TX word
// FIFOs. bus_wait/bus_readdata are registered on the strobe edge.
// Optional macro IO_FIFO_PORT_TIMEOUT_EN bounds stalls to WAIT_MAX cycles.
module io_fifo_port
    import io_fifo_port_pkg::*;
#(
    parameter logic [15:0] BASE       = 16'h0300,
    parameter int          DEPTH_LOG2 = 4,
    parameter int          WAIT_MAX   = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_address,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [2:0]  bus_datasize,
    input  logic [31:0] bus_writedata,
    output logic [31:0] bus_readdata,
    output logic        bus_wait,
    output logic        bus_io32,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] rx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_data
);

    logic        sel;
    logic [1:0]  off;
    logic        strobe;
    logic        io32_en;

    state_t      state;
    logic        pend_io32;
    logic [31:0] pend_wdata;
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [23:0] staging;
    logic        rx_unf;
    logic        tx_ovf;

    logic [31:0] rx_head;
    logic        rx_full;
    logic        rx_empty;
    logic        rx_pop;
    logic [31:0] tx_head;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_push;
    logic [31:0] tx_wdata;
    logic        flush;

    logic        acc_valid;
    logic        acc_read;
    logic        acc_io32;
    logic [1:0]  acc_off;
    logic [31:0] acc_wdata;
    logic        can_complete;
    logic        complete;
    logic        stall_start;
    logic [31:0] rdata_next;
    logic [STAT_W-1:0] status_word;

    assign sel      = (bus_address[15:2] == BASE[15:2]);
    assign off      = bus_address[1:0];
    assign strobe   = bus_read || bus_write;
    assign bus_io32 = sel && (off == OFF_DATA) && io32_en && (bus_datasize == 3'd4);

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_head;

`ifdef IO_FIFO_PORT_TIMEOUT_EN
    localparam int CW = $clog2(WAIT_MAX + 1);
    logic [CW-1:0] wait_cnt;
    logic          timeout;
    assign timeout = (state != IDLE) && !can_complete && (wait_cnt == CW'(WAIT_MAX - 1));
`else
    logic unused_wait_max;
    assign unused_wait_max = ^WAIT_MAX;
    assign rx_unf = 1'b0;
    assign tx_ovf = 1'b0;
`endif

    // A new strobe is only looked at in IDLE; a stalled access replays from latched state
    always_comb begin
        acc_valid = 1'b0;
        acc_read  = 1'b0;
        acc_io32  = 1'b0;
        acc_off   = OFF_DATA;
        acc_wdata = bus_writedata;
        case (state)
            IDLE: begin
                acc_valid = strobe && sel;
                acc_read  = bus_read;
                acc_io32  = bus_io32;
                acc_off   = off;
            end
            RD_WAIT: begin
                acc_valid = 1'b1;
                acc_read  = 1'b1;
                acc_io32  = pend_io32;
                acc_wdata = pend_wdata;
            end
            WR_WAIT: begin
                acc_valid = 1'b1;
                acc_io32  = pend_io32;
                acc_wdata = pend_wdata;
            end
            default: ;
        endcase
    end

    // STATUS register image
    always_comb begin
        status_word                        = '0;
        status_word[STAT_RX_NONEMPTY]      = !rx_empty;
        status_word[STAT_TX_FULL]          = tx_full;
        status_word[STAT_RX_UNF]           = rx_unf;
        status_word[STAT_TX_OVF]           = tx_ovf;
        status_word[STAT_RD_PTR +: 2]      = rd_ptr;
        status_word[STAT_WR_PTR +: 2]      = wr_ptr;
    end

    // Completion condition, FIFO side effects and read data for the current access
    always_comb begin
        can_complete = 1'b1;
        rx_pop       = 1'b0;
        tx_push      = 1'b0;
        tx_wdata     = acc_wdata;
        flush        = 1'b0;
        rdata_next   = '0;
        case (acc_off)
            OFF_DATA: begin
                if (acc_read) begin
                    if (acc_io32) begin
                        can_complete = !rx_empty;
                        rx_pop       = acc_valid && can_complete;
                        rdata_next   = rx_head;
                    end else begin
                        can_complete = !((rd_ptr == 2'd0) && rx_empty);
                        rx_pop       = acc_valid && can_complete && (rd_ptr == 2'd3);
                        rdata_next   = {24'b0, rx_head[{rd_ptr, 3'b000} +: 8]};
                    end
                end else begin
                    if (acc_io32) begin
                        can_complete = !tx_full;
                        tx_push      = acc_valid && can_complete;
                    end else begin
                        can_complete = !((wr_ptr == 2'd3) && tx_full);
                        tx_push      = acc_valid && can_complete && (wr_ptr == 2'd3);
                        tx_wdata     = {acc_wdata[7:0], staging};
                    end
                end
            end
            OFF_STATUS: rdata_next = {{(32-STAT_W){1'b0}}, status_word};
            OFF_CTRL: begin
                rdata_next = {31'b0, io32_en};
                flush      = acc_valid && !acc_read && acc_wdata[CTRL_FLUSH];
            end
            OFF_RSVD: rdata_next = '0;
            default: ;
        endcase
    end

    assign complete    = acc_valid && can_complete;
    assign stall_start = (state == IDLE) && acc_valid && !can_complete;

    // Bus-side FSM with registered wait/readdata and pointer/control state
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus_wait     <= 1'b0;
            bus_readdata <= '0;
            pend_io32    <= 1'b0;
            pend_wdata   <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            staging      <= '0;
            io32_en      <= 1'b0;
`ifdef IO_FIFO_PORT_TIMEOUT_EN
            rx_unf       <= 1'b0;
            tx_ovf       <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else if (complete) begin
            state        <= IDLE;
            bus_wait     <= 1'b0;
            bus_readdata <= acc_read ? rdata_next : '0;
            if ((acc_off == OFF_DATA) && !acc_io32) begin
                if (acc_read) begin
                    rd_ptr <= rd_ptr + 2'd1;
                end else begin
                    case (wr_ptr)
                        2'd0:    staging[7:0]   <= acc_wdata[7:0];
                        2'd1:    staging[15:8]  <= acc_wdata[7:0];
                        2'd2:    staging[23:16] <= acc_wdata[7:0];
                        default: ;
                    endcase
                    wr_ptr <= wr_ptr + 2'd1;
                end
            end
            if (!acc_read && (acc_off == OFF_CTRL)) begin
                io32_en <= acc_wdata[CTRL_IO32_EN];
                if (acc_wdata[CTRL_FLUSH]) begin
                    rd_ptr  <= '0;
                    wr_ptr  <= '0;
                    staging <= '0;
                end
`ifdef IO_FIFO_PORT_TIMEOUT_EN
                if (acc_wdata[CTRL_CLR_STICKY]) begin
                    rx_unf <= 1'b0;
                    tx_ovf <= 1'b0;
                end
`endif
            end
        end else if (stall_start) begin
            state        <= bus_read ? RD_WAIT : WR_WAIT;
            bus_wait     <= 1'b1;
            bus_readdata <= '0;
            pend_io32    <= bus_io32;
            pend_wdata   <= bus_writedata;
`ifdef IO_FIFO_PORT_TIMEOUT_EN
            wait_cnt     <= '0;
        end else if (timeout) begin
            state    <= IDLE;
            bus_wait <= 1'b0;
            if (state == RD_WAIT) begin
                bus_readdata <= pend_io32 ? 32'hFFFF_FFFF : 32'h0000_00FF;
                rx_unf       <= 1'b1;
            end else begin
                bus_readdata <= '0;
                tx_ovf       <= 1'b1;
            end
        end else if (state != IDLE) begin
            wait_cnt <= wait_cnt + CW'(1);
`endif
        end else if ((state == IDLE) && strobe) begin
            bus_wait     <= 1'b0;
            bus_readdata <= '0;
        end
    end

    io_fifo_port_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    io_fifo_port_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (tx_push),
        .push_data (tx_wdata),
        .pop       (tx_ready),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

endmodule

// File: tb/tb_io_fifo_port.sv
// Self-checking bench for io_fifo_port: directed scenarios plus a randomized
// mix of bus and backend traffic checked against queue-based reference model.
module tb_io_fifo_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [2:0]  bus_datasize;
    logic [31:0] bus_writedata;
    logic [31:0] bus_readdata;
    logic        bus_wait;
    logic        bus_io32;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] rxq[$];
    logic [31:0] txq[$];
    int          m_rd_ptr;
    int          m_wr_ptr;
    logic [7:0]  m_stage[3];
    logic        m_io32;

    always #5 clk = ~clk;

    io_fifo_port #(
        .BASE       (16'h0300),
        .DEPTH_LOG2 (4),
        .WAIT_MAX   (1023)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_address   (bus_address),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .bus_datasize  (bus_datasize),
        .bus_writedata (bus_writedata),
        .bus_readdata  (bus_readdata),
        .bus_wait      (bus_wait),
        .bus_io32      (bus_io32),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data)
    );

    function automatic void model_clear_fifos();
        rxq.delete();
        txq.delete();
        m_rd_ptr = 0;
        m_wr_ptr = 0;
        for (int i = 0; i < 3; i++) m_stage[i] = 8'h00;
    endfunction

    function automatic logic [31:0] model_status();
        return {24'b0, 2'(m_wr_ptr), 2'(m_rd_ptr), 2'b00,
                (txq.size() == 16), (rxq.size() != 0)};
    endfunction

    // One initiator access; called #1 after a rising edge. Returns data once bus_wait is low.
    task automatic bus_access(input logic rd, input logic [15:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output int waits, output logic io32);
        bus_address   = addr;
        bus_datasize  = size;
        bus_writedata = wdata;
        bus_read      = rd;
        bus_write     = !rd;
        #1 io32 = bus_io32;
        @(posedge clk); #1;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        waits = 0;
        while (bus_wait === 1'b1 && waits < 200) begin
            @(posedge clk); #1;
            waits++;
        end
        rdata = bus_readdata;
    endtask

    task automatic be_push(input logic [31:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic be_pop();
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic ctrl_write(input logic [31:0] v);
        logic [31:0] r; int wt; logic f;
        bus_access(1'b0, 16'h0302, 3'd1, v, r, wt, f);
        m_io32 = v[0];
        if (v[1]) model_clear_fifos();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear_fifos();
        m_io32 = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r; int wt; logic f;
        do_reset();
        n_cmp++; if (bus_wait !== 1'b0) begin n_err++; $display("FAIL reset_wait: got %b want 0", bus_wait); end
        n_cmp++; if (bus_readdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus_readdata); end
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        bus_access(1'b1, 16'h0301, 3'd1, 32'h0, r, wt, f);
        n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", r); end
        bus_access(1'b1, 16'h0302, 3'd1, 32'h0, r, wt, f);
        n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", r); end
    endtask

    task automatic test_io32_read();
        logic [31:0] r; int wt; logic f;
        ctrl_write(32'h1);
        be_push(32'hAABBCCDD); rxq.push_back(32'hAABBCCDD);
        bus_access(1'b1, 16'h0300, 3'd4, 32'h0, r, wt, f);
        r = r; void'(rxq.pop_front());
        n_cmp++; if (f !== 1'b1) begin n_err++; $display("FAIL io32_flag: got %b want 1", f); end
        n_cmp++; if (wt !== 0) begin n_err++; $display("FAIL io32_waits: got %0d want 0", wt); end
        n_cmp++; if (r !== 32'hAABBCCDD) begin n_err++; $display("FAIL io32_data: got %h want aabbccdd", r); end
        bus_access(1'b1, 16'h0301, 3'd1, 32'h0, r, wt, f);
        n_cmp++; if (r !== model_status()) begin n_err++; $display("FAIL io32_status: got %h want %h", r, model_status()); end
    endtask

    task automatic test_byte_read();
        logic [31:0] r; logic [31:0] exp; int wt; logic f;
        ctrl_write(32'h0);
        be_push(32'hAABBCCDD); rxq.push_back(32'hAABBCCDD);
        for (int k = 0; k < 4; k++) begin
            exp = (rxq[0] >> (8 * m_rd_ptr)) & 32'hFF;
            if (m_rd_ptr == 3) void'(rxq.pop_front());
            m_rd_ptr = (m_rd_ptr + 1) % 4;
            bus_access(1'b1, 16'h0300, 3'(4 - k), 32'h0, r, wt, f);
            n_cmp++; if (r !== exp || f !== 1'b0) begin n_err++; $display("FAIL byte_read_%0d: got %h io32 %b want %h io32 0", k, r, f, exp); end
            bus_access(1'b1, 16'h0301, 3'd1, 32'h0, r, wt, f);
            n_cmp++; if (r !== model_status()) begin n_err++; $display("FAIL byte_status_%0d: got %h want %h", k, r, model_status()); end
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] r; int wt; logic f;
        ctrl_write(32'h1);
        fork
            bus_access(1'b1, 16'h0300, 3'd4, 32'h0, r, wt, f);
            begin
                repeat (9) @(posedge clk);
                #1 rx_valid = 1'b1; rx_data = 32'h11223344;
                @(posedge clk); #1 rx_valid = 1'b0;
            end
        join
        n_cmp++; if (wt !== 10) begin n_err++; $display("FAIL rd_stall_waits: got %0d want 10", wt); end
        n_cmp++; if (r !== 32'h11223344) begin n_err++; $display("FAIL rd_stall_data: got %h want 11223344", r); end
    endtask

    task automatic test_write_stall();
        logic [31:0] r; logic [31:0] w; int wt; logic f;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            bus_access(1'b0, 16'h0300, 3'd4, w, r, wt, f);
            txq.push_back(w);
            n_cmp++; if (wt !== 0) begin n_err++; $display("FAIL fill_waits_%0d: got %0d want 0", i, wt); end
        end
        bus_access(1'b1, 16'h0301, 3'd1, 32'h0, r, wt, f);
        n_cmp++; if (r !== model_status()) begin n_err++; $display("FAIL full_status: got %h want %h", r, model_status()); end
        fork
            bus_access(1'b0, 16'h0300, 3'd4, 32'hCAFEF00D, r, wt, f);
            begin
                repeat (4) @(posedge clk);
                #1;
                n_cmp++; if (tx_data !== txq[0]) begin n_err++; $display("FAIL stall_pop_data: got %h want %h", tx_data, txq[0]); end
                be_pop();
                void'(txq.pop_front());
            end
        join
        txq.push_back(32'hCAFEF00D);
        n_cmp++; if (wt !== 5) begin n_err++; $display("FAIL wr_stall_waits: got %0d want 5", wt); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin n_err++; $display("FAIL drain_%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, txq[0]); end
            be_pop();
            void'(txq.pop_front());
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", tx_valid); end
    endtask

    task automatic test_unselected_and_reset();
        logic [31:0] r; int wt; logic f;
        ctrl_write(32'h1);
        bus_access(1'b1, 16'h0302, 3'd1, 32'h0, r, wt, f);
        n_cmp++; if (r !== 32'h1) begin n_err++; $display("FAIL ctrl_read: got %h want 1", r); end
        bus_access(1'b1, 16'h0304, 3'd4, 32'h0, r, wt, f);
        n_cmp++; if (r !== 32'h0 || wt !== 0 || f !== 1'b0) begin n_err++; $display("FAIL unsel_read: got %h waits %0d io32 %b want 0/0/0", r, wt, f); end
        bus_access(1'b1, 16'h0303, 3'd1, 32'h0, r, wt, f);
        n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL rsvd_read: got %h want 0", r); end
        bus_access(1'b0, 16'h0300, 3'd4, 32'h12345678, r, wt, f);
        // Stall an io32 read on empty RX, then reset mid-stall
        bus_address = 16'h0300; bus_datasize = 3'd4; bus_read = 1'b1;
        @(posedge clk); #1 bus_read = 1'b0;
        n_cmp++; if (bus_wait !== 1'b1) begin n_err++; $display("FAIL midstall_wait: got %b want 1", bus_wait); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_clear_fifos(); m_io32 = 1'b0;
        n_cmp++; if (bus_wait !== 1'b0 || bus_readdata !== 32'h0) begin n_err++; $display("FAIL midstall_reset: got %b/%h want 0/0", bus_wait, bus_readdata); end
        n_cmp++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin n_err++; $display("FAIL midstall_fifos: got tx_valid %b rx_ready %b want 0/1", tx_valid, rx_ready); end
        bus_access(1'b1, 16'h0301, 3'd1, 32'h0, r, wt, f);
        n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL midstall_status: got %h want 0", r); end
    endtask

    task automatic test_random();
        logic [31:0] r; logic [31:0] w; logic [31:0] exp; int wt; logic f;
        logic [2:0] size; logic io; int op;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 6);
            case (op)
                0: begin
                    n_cmp++; if (rx_ready !== (rxq.size() < 16)) begin n_err++; $display("FAIL rnd_rx_ready: got %b want %b", rx_ready, rxq.size() < 16); end
                    if (rxq.size() < 16) begin w = $urandom; be_push(w); rxq.push_back(w); end
                end
                1: begin
                    n_cmp++; if (tx_valid !== (txq.size() != 0)) begin n_err++; $display("FAIL rnd_tx_valid: got %b want %b", tx_valid, txq.size() != 0); end
                    if (txq.size() != 0) begin
                        n_cmp++; if (tx_data !== txq[0]) begin n_err++; $display("FAIL rnd_tx_data: got %h want %h", tx_data, txq[0]); end
                        be_pop();
                        w = txq.pop_front();
                    end
                end
                2: begin
                    size = 3'($urandom_range(1, 4));
                    io = m_io32 && size == 3'd4;
                    if (io ? (rxq.size() != 0 && m_rd_ptr == 0) : !(m_rd_ptr == 0 && rxq.size() == 0)) begin
                        if (io) exp = rxq.pop_front();
                        else begin
                            exp = (rxq[0] >> (8 * m_rd_ptr)) & 32'hFF;
                            if (m_rd_ptr == 3) w = rxq.pop_front();
                            m_rd_ptr = (m_rd_ptr + 1) % 4;
                        end
                        bus_access(1'b1, 16'h0300, size, $urandom, r, wt, f);
                        n_cmp++; if (r !== exp || wt !== 0 || f !== io) begin n_err++; $display("FAIL rnd_read: got %h waits %0d io32 %b want %h 0 %b", r, wt, f, exp, io); end
                    end
                end
                3: begin
                    size = 3'($urandom_range(1, 4));
                    io = m_io32 && size == 3'd4;
                    w = $urandom;
                    if (io ? (txq.size() < 16 && m_wr_ptr == 0) : !(m_wr_ptr == 3 && txq.size() == 16)) begin
                        bus_access(1'b0, 16'h0300, size, w, r, wt, f);
                        n_cmp++; if (wt !== 0 || f !== io) begin n_err++; $display("FAIL rnd_write: got waits %0d io32 %b want 0 %b", wt, f, io); end
                        if (io) txq.push_back(w);
                        else if (m_wr_ptr == 3) begin
                            txq.push_back({w[7:0], m_stage[2], m_stage[1], m_stage[0]});
                            m_wr_ptr = 0;
                        end else begin
                            m_stage[m_wr_ptr] = w[7:0];
                            m_wr_ptr++;
                        end
                    end
                end
                4: begin
                    bus_access(1'b1, 16'h0301, 3'd1, 32'h0, r, wt, f);
                    n_cmp++; if (r !== model_status()) begin n_err++; $display("FAIL rnd_status: got %h want %h", r, model_status()); end
                end
                5: begin
                    w = ($urandom & 32'h0000_0005) | (($urandom_range(0, 9) == 0) ? 32'h2 : 32'h0);
                    ctrl_write(w);
                end
                default: begin
                    bus_access(1'b1, 16'h0302, 3'd1, 32'h0, r, wt, f);
                    n_cmp++; if (r !== {31'b0, m_io32}) begin n_err++; $display("FAIL rnd_ctrl: got %h want %h", r, {31'b0, m_io32}); end
                end
            endcase
        end
        while (txq.size() != 0) begin
            n_cmp++; if (tx_data !== txq[0]) begin n_err++; $display("FAIL rnd_drain: got %h want %h", tx_data, txq[0]); end
            be_pop();
            w = txq.pop_front();
        end
    endtask

    initial begin
        reset = 1'b1; bus_address = '0; bus_read = 1'b0; bus_write = 1'b0;
        bus_datasize = 3'd1; bus_writedata = '0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        m_io32 = 1'b0;
        model_clear_fifos();
        @(posedge clk); #1;
        test_reset();
        test_io32_read();
        test_byte_read();
        test_read_stall();
        test_write_stall();
        test_unselected_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_fifo_port.md
Name: io_fifo_port

Overview:
- Responder (target) end of the byte-serial CPU I/O bus.
- Decodes a 4-port window, answers bus_read/bus_write strobes with registered bus_wait/bus_readdata, and advertises 32-bit capability via bus_io32.
- Bridges a data port to word-wide RX/TX FIFOs toward a peripheral backend (disk/serial-style controllers).

Parameters:
- BASE, 16'h0300, window base address; BASE[1:0] must be 0.
- DEPTH_LOG2, 4, log2 FIFO depth in 32-bit words (each direction).
- WAIT_MAX, 1023, wait-cycle limit before a timed-out access completes (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- bus_address  in  16  port address
- bus_read  in  1  one-cycle read strobe
- bus_write  in  1  one-cycle write strobe
- bus_datasize  in  3  bytes remaining in the initiator access (1..4)
- bus_writedata  in  32  write data; byte mode uses [7:0]
- bus_readdata  out  32  read data; 0 when not selected (OR-combinable)
- bus_wait  out  1  stall; 0 when not selected
- bus_io32  out  1  combinational: current access is one 32-bit transfer
- rx_valid  in  1  backend word push request
- rx_ready  out  1  = RX not full
- rx_data  in  32  backend word
- tx_valid  out  1  = TX not empty
- tx_ready  in  1  backend pop
- tx_data  out  32  TX head word (first-word-fall-through)

Behaviour:
- Select: bus_address[15:2]==BASE[15:2]; off=bus_address[1:0]. Off 0 DATA, 1 STATUS (RO), 2 CTRL, 3 reserved (reads 0, writes ignored).
- bus_io32 = sel & off==0 & ctrl_io32 & bus_datasize==4; all other accesses use the byte path.
- Timing: strobe sampled at edge N. bus_wait and bus_readdata are registered at edge N and must be valid from N+1, because the initiator samples them at edge N+2. No-stall latency is therefore 1 cycle. While stalled, bus_wait stays 1. When bus_wait falls, bus_readdata is already valid in the same cycle and holds until the next strobe.
- States: IDLE, RD_WAIT, WR_WAIT.
  - IDLE: a selected strobe that can complete immediately sets bus_wait=0 and performs the action. Otherwise it sets bus_wait=1 and moves to RD_WAIT or WR_WAIT. Each WAIT state returns to IDLE on completion.
- DATA read, io32: pop RX head, bus_readdata = head word; stall while RX empty.
- DATA read, byte mode: bus_readdata = {24'b0, head byte rd_ptr}, rd_ptr increments; pop when rd_ptr wraps 3->0; stall only when rd_ptr==0 and RX empty.
- DATA write, io32: push bus_writedata; stall while TX full.
- DATA write, byte mode: byte goes into staging lane wr_ptr; on wr_ptr==3 push {byte, staging[23:0]}; stall only on that push while TX full.
- STATUS = {2'b0, wr_ptr, rd_ptr, tx_ovf, rx_unf, tx_full, rx_nonempty}.
- CTRL write:
  - bit0 io32_en (R/W).
  - bit1 flush (self-clearing): empty both FIFOs, zero rd_ptr/wr_ptr/staging.
  - bit2: write 1 clears the sticky bits.
  - CTRL read = {7'b0, io32_en}.
- Backend: push when rx_valid & rx_ready; pop when tx_valid & tx_ready. A simultaneous bus pop and backend push on the same FIFO are both honoured.
- Strobe arriving while in a WAIT state is ignored (protocol violation; the initiator never does this).
- Reset (including mid-stall):
  - bus_wait=0, bus_readdata=0, FIFOs empty, pointers/staging/ctrl/sticky=0, state IDLE.
  - The pending access is abandoned.

Optional Feature:
- IO_FIFO_PORT_TIMEOUT_EN defined:
  - A wait counter runs while in RD_WAIT/WR_WAIT.
  - After WAIT_MAX cycles the access completes with bus_wait=0.
  - A read returns all-ones (32'hFFFFFFFF io32, 8'hFF byte), sets rx_unf, and neither pops nor advances rd_ptr.
  - A write is dropped, sets tx_ovf, and does not advance wr_ptr.
- IO_FIFO_PORT_TIMEOUT_EN undefined: stalls are unbounded, the counter is absent, and rx_unf/tx_ovf read 0.

Decomposition:
- Package io_fifo_port_pkg holds:
  - offset constants DATA/STATUS/CTRL.
  - CTRL/STATUS bit-index constants.
  - the state enum.
- One sub-module, io_fifo_port_fifo: synchronous first-word-fall-through FIFO with full/empty, instantiated twice.

Test Plan:
- CTRL=1, RX preloaded 32'hAABBCCDD, 4-byte read at 0x300 -> bus_io32=1, single strobe, bus_wait=0, readdata 32'hAABBCCDD, RX empty.
- CTRL=0, same preload, four byte reads at 0x300 -> 8'hDD, 8'hCC, 8'hBB, 8'hAA; pop only after the 4th; STATUS rd_ptr goes 1,2,3,0.
- RX empty, read DATA, backend pushes 32'h11223344 ten cycles later -> bus_wait high ~10 cycles, falls with readdata 32'h11223344 valid the same cycle.
- TX full (16 words), io32 write 32'hCAFEF00D, tx_ready pulsed after 5 cycles -> stall released, word enters TX, no loss.
- With IO_FIFO_PORT_TIMEOUT_EN and WAIT_MAX=8, read of empty RX -> bus_wait falls after 8 cycles, data 32'hFFFFFFFF, STATUS bit2=1; CTRL write 4 clears it.
- Reset asserted mid-stall; also a read at 0x304 -> bus_wait=0, readdata 0, FIFOs empty; unselected address gets no wait and readdata 0.
